// File: rtl/fifo_rd_stream.sv
// Read-side front end for a synchronous FIFO: prefetches up to two words and
// presents them on a valid/ready stream with run/stop, flush and status.
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 flush_i,
    input  logic                 clr_err_i,
    input  logic                 empty_i,
    input  logic [WIDTH-1:0]     rdata_i,
    input  logic                 rd_error_i,
    output logic                 rd_en_o,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [CNT_WIDTH-1:0] words_o,
    output logic                 underflow_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       occ;
    logic             pend;
    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;

    logic             pop;
    logic [1:0]       tail;
    logic [1:0]       load;

    assign m_valid_o = (occ != 2'd0) && (state != FLUSH);
    assign m_data_o  = ent0;
    assign busy_o    = (state != IDLE);

    // tail is where a landing word goes after this cycle's pop; load is the
    // committed occupancy (buffered + in flight) once this cycle completes.
    always_comb begin
        pop     = m_valid_o & m_ready_i;
        tail    = occ - {1'b0, pop};
        load    = tail + {1'b0, pend};
        rd_en_o = (state == RUN) && !empty_i && (load < 2'd2);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            occ         <= '0;
            pend        <= 1'b0;
            ent0        <= '0;
            ent1        <= '0;
            words_o     <= '0;
            underflow_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i)       state <= FLUSH;
                    else if (enable_i) state <= RUN;
                end
                RUN: begin
                    if (flush_i)       state <= FLUSH;
                    else if (!enable_i) state <= IDLE;
                end
                FLUSH: begin
                    if (!pend)         state <= IDLE;
                end
                default:               state <= IDLE;
            endcase

            pend <= rd_en_o;

            // Flush drops the buffer and any word landing on this edge.
            if (flush_i || state == FLUSH) begin
                occ <= '0;
            end else begin
                occ <= load;
                if (pop) ent0 <= ent1;
                if (pend) begin
                    if (tail == 2'd0) ent0 <= rdata_i;
                    else              ent1 <= rdata_i;
                end
            end

            if (pop && (words_o != '1)) words_o <= words_o + CNT_WIDTH'(1);

            if (rd_error_i)     underflow_o <= 1'b1;
            else if (clr_err_i) underflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: vector table plus flush, saturation and
// asynchronous reset sequences against a small behavioural FIFO.
module tb_fifo_rd_stream;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i, flush_i, clr_err_i, rd_error_i, m_ready_i;
    logic        empty_i;
    logic [7:0]  rdata_i = '0;
    logic        rd_en_o, m_valid_o, underflow_o, busy_o;
    logic [7:0]  m_data_o;
    logic [15:0] words_o;
    logic        rd_en_s, m_valid_s, underflow_s, busy_s;
    logic [7:0]  m_data_s;
    logic [3:0]  words_s;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
        .clr_err_i(clr_err_i), .empty_i(empty_i), .rdata_i(rdata_i),
        .rd_error_i(rd_error_i), .rd_en_o(rd_en_o), .m_data_o(m_data_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .words_o(words_o),
        .underflow_o(underflow_o), .busy_o(busy_o)
    );

    // Narrow-counter copy on the same stimulus, used for saturation.
    fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(4)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
        .clr_err_i(clr_err_i), .empty_i(empty_i), .rdata_i(rdata_i),
        .rd_error_i(rd_error_i), .rd_en_o(rd_en_s), .m_data_o(m_data_s),
        .m_valid_o(m_valid_s), .m_ready_i(m_ready_i), .words_o(words_s),
        .underflow_o(underflow_s), .busy_o(busy_s)
    );

    // Behavioural FIFO: one-cycle read latency, pushes from the stimulus.
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       fifo_clr;

    assign empty_i = (rd_ptr == wr_ptr);

    always @(posedge clk_i) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (rd_en_o) begin
            rdata_i <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    task automatic push(input int base, input int n);
        for (int j = 0; j < n; j++) begin
            mem[wr_ptr] = 8'(base + j);
            wr_ptr      = wr_ptr + 1;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    typedef struct {
        logic en, fl, rdy, err, clr;
        int   pb, pn;
        logic xr, xv;
        int   xd, xw;
        logic xb, xu;
    } vec_t;

    function automatic vec_t mk(input logic en, fl, rdy, err, clr, input int pb, pn,
                                input logic xr, xv, input int xd, xw, input logic xb, xu);
        vec_t v;
        v.en = en; v.fl = fl; v.rdy = rdy; v.err = err; v.clr = clr;
        v.pb = pb; v.pn = pn;
        v.xr = xr; v.xv = xv; v.xd = xd; v.xw = xw; v.xb = xb; v.xu = xu;
        return v;
    endfunction

    localparam int NV = 43;
    vec_t vt [NV];

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int got;
        int n;

        //           en fl rdy er cl  pb    pn   rd val data   wds busy uf
        vt[0]  = mk(1, 0, 1, 0, 0, 'h10, 8,  0, 0, 0,     0,  0, 0);
        vt[1]  = mk(1, 0, 1, 0, 0, 0,    0,  1, 0, 0,     0,  1, 0);
        vt[2]  = mk(1, 0, 1, 0, 0, 0,    0,  1, 0, 0,     0,  1, 0);
        vt[3]  = mk(1, 0, 1, 0, 0, 0,    0,  1, 1, 'h10,  0,  1, 0);
        vt[4]  = mk(1, 0, 1, 0, 0, 0,    0,  1, 1, 'h11,  1,  1, 0);
        vt[5]  = mk(1, 0, 1, 0, 0, 0,    0,  1, 1, 'h12,  2,  1, 0);
        vt[6]  = mk(1, 0, 1, 0, 0, 0,    0,  1, 1, 'h13,  3,  1, 0);
        vt[7]  = mk(1, 0, 1, 0, 0, 0,    0,  1, 1, 'h14,  4,  1, 0);
        vt[8]  = mk(1, 0, 1, 0, 0, 0,    0,  1, 1, 'h15,  5,  1, 0);
        vt[9]  = mk(1, 0, 1, 0, 0, 0,    0,  0, 1, 'h16,  6,  1, 0);
        vt[10] = mk(1, 0, 1, 0, 0, 0,    0,  0, 1, 'h17,  7,  1, 0);
        vt[11] = mk(1, 0, 0, 0, 0, 'h20, 4,  1, 0, 0,     8,  1, 0);
        vt[12] = mk(1, 0, 0, 0, 0, 0,    0,  1, 0, 0,     8,  1, 0);
        vt[13] = mk(1, 0, 0, 0, 0, 0,    0,  0, 1, 'h20,  8,  1, 0);
        vt[14] = mk(1, 0, 0, 0, 0, 0,    0,  0, 1, 'h20,  8,  1, 0);
        vt[15] = mk(1, 0, 0, 0, 0, 0,    0,  0, 1, 'h20,  8,  1, 0);
        vt[16] = mk(1, 0, 1, 0, 0, 0,    0,  1, 1, 'h20,  8,  1, 0);
        vt[17] = mk(1, 0, 1, 0, 0, 0,    0,  1, 1, 'h21,  9,  1, 0);
        vt[18] = mk(1, 0, 1, 0, 0, 0,    0,  0, 1, 'h22, 10,  1, 0);
        vt[19] = mk(1, 0, 1, 0, 0, 0,    0,  0, 1, 'h23, 11,  1, 0);
        vt[20] = mk(1, 0, 1, 0, 0, 0,    0,  0, 0, 0,    12,  1, 0);
        vt[21] = mk(1, 0, 0, 0, 0, 'h30, 3,  1, 0, 0,    12,  1, 0);
        vt[22] = mk(1, 0, 0, 0, 0, 0,    0,  1, 0, 0,    12,  1, 0);
        vt[23] = mk(1, 0, 0, 0, 0, 0,    0,  0, 1, 'h30, 12,  1, 0);
        vt[24] = mk(0, 0, 0, 0, 0, 0,    0,  0, 1, 'h30, 12,  1, 0);
        vt[25] = mk(0, 0, 1, 0, 0, 0,    0,  0, 1, 'h30, 12,  0, 0);
        vt[26] = mk(0, 0, 1, 0, 0, 0,    0,  0, 1, 'h31, 13,  0, 0);
        vt[27] = mk(0, 0, 1, 0, 0, 0,    0,  0, 0, 0,    14,  0, 0);
        vt[28] = mk(1, 0, 1, 0, 0, 'h33, 2,  0, 0, 0,    14,  0, 0);
        vt[29] = mk(1, 0, 1, 0, 0, 0,    0,  1, 0, 0,    14,  1, 0);
        vt[30] = mk(1, 1, 1, 0, 0, 0,    0,  1, 0, 0,    14,  1, 0);
        vt[31] = mk(0, 0, 1, 0, 0, 0,    0,  0, 0, 0,    14,  1, 0);
        vt[32] = mk(0, 0, 1, 0, 0, 0,    0,  0, 0, 0,    14,  1, 0);
        vt[33] = mk(1, 0, 1, 0, 0, 0,    0,  0, 0, 0,    14,  0, 0);
        vt[34] = mk(1, 0, 1, 0, 0, 0,    0,  1, 0, 0,    14,  1, 0);
        vt[35] = mk(1, 0, 1, 0, 0, 0,    0,  0, 0, 0,    14,  1, 0);
        vt[36] = mk(1, 0, 1, 0, 0, 0,    0,  0, 1, 'h34, 14,  1, 0);
        vt[37] = mk(0, 0, 1, 0, 0, 0,    0,  0, 0, 0,    15,  1, 0);
        vt[38] = mk(0, 0, 1, 1, 0, 0,    0,  0, 0, 0,    15,  0, 0);
        vt[39] = mk(0, 0, 1, 0, 0, 0,    0,  0, 0, 0,    15,  0, 1);
        vt[40] = mk(0, 0, 1, 1, 1, 0,    0,  0, 0, 0,    15,  0, 1);
        vt[41] = mk(0, 0, 1, 0, 1, 0,    0,  0, 0, 0,    15,  0, 1);
        vt[42] = mk(0, 0, 1, 0, 0, 0,    0,  0, 0, 0,    15,  0, 0);

        rst_i = 1'b0; fifo_clr = 1'b1;
        enable_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0; rd_error_i = 1'b0; m_ready_i = 1'b0;
        #12;
        chk("rst_rd_en", 0, rd_en_o, 0);
        chk("rst_valid", 0, m_valid_o, 0);
        chk("rst_data",  0, m_data_o, 0);
        chk("rst_words", 0, words_o, 0);
        chk("rst_uf",    0, underflow_o, 0);
        chk("rst_busy",  0, busy_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        fifo_clr = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step();
            if (vt[i].pn > 0) push(vt[i].pb, vt[i].pn);
            enable_i   = vt[i].en;
            flush_i    = vt[i].fl;
            m_ready_i  = vt[i].rdy;
            rd_error_i = vt[i].err;
            clr_err_i  = vt[i].clr;
            #1;
            chk("rd_en", i, rd_en_o, vt[i].xr);
            chk("valid", i, m_valid_o, vt[i].xv);
            if (vt[i].xv) chk("data", i, m_data_o, vt[i].xd);
            chk("words", i, words_o, vt[i].xw);
            chk("words_sat", i, words_s, (vt[i].xw > 15) ? 15 : vt[i].xw);
            chk("busy", i, busy_o, vt[i].xb);
            chk("uf", i, underflow_o, vt[i].xu);
        end
        rd_error_i = 1'b0; clr_err_i = 1'b0; flush_i = 1'b0;

        // Flush on a cycle where a handshake completes and a read is in flight.
        push('h40, 3);
        enable_i = 1'b1; m_ready_i = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            step();
            if (m_valid_o) got = 1;
        end
        chk("fl_valid_seen", 0, got, 1);
        chk("fl_head", 0, m_data_o, 'h40);
        flush_i = 1'b1; enable_i = 1'b0;
        step();
        flush_i = 1'b0;
        chk("fl_valid_after", 0, m_valid_o, 0);
        chk("fl_words", 0, words_o, 16);
        chk("fl_busy", 0, busy_o, 1);
        chk("fl_rd_en", 0, rd_en_o, 0);
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            step();
            if (!busy_o) got = 1;
        end
        chk("fl_idle", 0, got, 1);

        // Stream eight more words; narrow counter must sit at its ceiling.
        push('h50, 8);
        enable_i = 1'b1; m_ready_i = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            chk("rd_when_empty", k, rd_en_o & empty_i, 0);
            if (m_valid_o) begin
                chk("sat_data", n, m_data_o, 'h50 + n);
                n = n + 1;
            end
        end
        chk("sat_count", 0, n, 8);
        chk("sat_words", 0, words_o, 24);
        chk("sat_words_sat", 0, words_s, 15);
        enable_i = 1'b0;
        step();
        step();

        // Asynchronous reset dropped mid-cycle while the buffer is full.
        push('h60, 4);
        enable_i = 1'b1; m_ready_i = 1'b0; rd_error_i = 1'b1;
        step();
        rd_error_i = 1'b0;
        step(); step(); step();
        chk("pre_rst_valid", 0, m_valid_o, 1);
        chk("pre_rst_uf", 0, underflow_o, 1);
        #3;
        rst_i = 1'b0;
        #1;
        chk("arst_rd_en", 0, rd_en_o, 0);
        chk("arst_valid", 0, m_valid_o, 0);
        chk("arst_data",  0, m_data_o, 0);
        chk("arst_words", 0, words_o, 0);
        chk("arst_words_sat", 0, words_s, 0);
        chk("arst_uf",    0, underflow_o, 0);
        chk("arst_busy",  0, busy_o, 0);
        fifo_clr = 1'b1;
        step();
        @(negedge clk_i);
        rst_i = 1'b1;
        fifo_clr = 1'b0;
        enable_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Single-clock read-side front end for the team's FIFOs.
- Pulls words from a FIFO read port (rd_en / rdata / empty / rd_error) and presents them on a valid/ready stream through a 2-entry prefetch buffer.
- The prefetch buffer hides the FIFO's one-cycle read latency and sustains 1 word/clk.
- Adds run/stop control, flush, a saturating delivered-word counter and a sticky underflow flag.

Parameters:
- WIDTH, 8, data word width (matches FIFO WIDTH).
- CNT_WIDTH, 16, width of delivered-word counter.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- rst_i  input  1  reset, asynchronous, active-low.
- enable_i  input  1  1 = fetch from FIFO, 0 = stop fetching.
- flush_i  input  1  discard buffered and in-flight data.
- clr_err_i  input  1  clears underflow_o.
- empty_i  input  1  FIFO empty flag.
- rdata_i  input  WIDTH  FIFO read data, valid the cycle after an issued rd_en_o.
- rd_error_i  input  1  FIFO read-error strobe.
- rd_en_o  output  1  FIFO read request (combinational).
- m_data_o  output  WIDTH  stream data (head buffer entry).
- m_valid_o  output  1  stream valid.
- m_ready_i  input  1  stream ready.
- words_o  output  CNT_WIDTH  delivered-word count.
- underflow_o  output  1  sticky: FIFO reported rd_error.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset (rst_i=0, async, immediate):
  - state=IDLE, occ=0, pend=0, buffer entries=0.
  - Outputs: rd_en_o=0, m_valid_o=0, m_data_o=0, words_o=0, underflow_o=0, busy_o=0.
  - A read in flight at reset is lost; upstream FIFO must be reset together.
- Internal state:
  - occ = 0..2 entries held in the buffer.
  - pend = 1 if rd_en_o was issued last cycle (data lands this cycle).
  - Invariant: occ+pend <= 2.
- FSM transitions:
  - IDLE -> FLUSH if flush_i=1.
  - IDLE -> RUN if enable_i=1 and flush_i=0.
  - RUN -> FLUSH if flush_i=1 (priority over enable_i).
  - RUN -> IDLE if enable_i=0.
  - FLUSH -> IDLE the cycle after pend=0.
- pop = m_valid_o & m_ready_i.
- rd_en_o = (state==RUN) & ~empty_i & (occ + pend - pop < 2). Never asserted when empty_i=1. Combinational from m_ready_i.
- Landing: when pend=1, rdata_i is written to the tail entry. Same-cycle pop and land keeps occ unchanged. Entries are kept in FIFO order.
- Throughput: with m_ready_i held high and FIFO non-empty, one word per cycle after a 2-cycle start-up. First m_valid_o appears 2 clocks after entering RUN with empty_i=0.
- m_valid_o = (occ != 0) & (state != FLUSH).
- m_data_o = head entry; stable while m_valid_o & ~m_ready_i.
- IDLE with occ>0 or pend=1: no new reads. In-flight data still lands, and buffered words still drain to the stream.
- Flush:
  - In the cycle flush_i=1, a handshake still completes and is counted.
  - On that edge, the buffer is cleared (occ=0).
  - If pend=1, the landing word is discarded. FLUSH waits until pend=0, then returns to IDLE.
  - In FLUSH: rd_en_o=0 and m_valid_o=0.
- words_o: +1 per pop. Saturates at 2^CNT_WIDTH-1. Cleared only by reset.
- underflow_o:
  - Set on any cycle rd_error_i=1.
  - Cleared by clr_err_i=1.
  - Set wins when both are asserted in the same cycle.
  - Does not stop operation.
- busy_o = (state != IDLE).

Test Plan:
- Stream, no backpressure: FIFO preloaded with 0x10..0x17, enable_i=1, m_ready_i=1 -> first m_valid_o 2 clks after enable; 0x10..0x17 on 8 consecutive cycles; words_o=8; rd_en_o=0 once empty_i=1.
- Backpressure: 4 words queued, m_ready_i=0 for 5 clks -> occ saturates at 2 and rd_en_o=0; m_data_o holds first word; after ready rises, all 4 words arrive in order with no loss or duplication.
- Flush with read in flight: flush_i pulsed in the cycle after a rd_en_o -> landing word discarded; m_valid_o=0 the next cycle; busy_o drops after FLUSH exits; next enable resumes from the following FIFO word.
- Stop mid-stream: enable_i deasserted with occ=2, pend=0 -> no further rd_en_o; both buffered words still delivered; words_o increments by 2.
- Error and saturation: inject rd_error_i=1 -> underflow_o=1 and stays set; clr_err_i clears it; with CNT_WIDTH=4, 20 pops -> words_o=15.
- Async reset mid-stream: drop rst_i between clock edges -> all outputs zero immediately, without waiting for a clock edge.
